// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width defaults for the FIFO write arbiter.
// The SEND_ALU_HI state exists only when FIFO_WR_ARB_ALU_HI_EN is defined.
package fifo_wr_arb_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ALU_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_ALU_LO = 2'd1,
`ifdef FIFO_WR_ARB_ALU_HI_EN
    SEND_ALU_HI = 2'd2,
`endif
    SEND_RD     = 2'd3
  } state_e;

endpackage

// File: rtl/arb_req_slot.sv
// One requester capture slot: holds a result until its grant completes,
// and flags a drop when a new result finds the slot still occupied.
module arb_req_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_clr,
  output logic         o_pend,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  logic         r_pend;
  logic [W-1:0] r_data;
  logic         r_drop;
  logic         w_accept;

  // A pulse landing on the final-byte cycle reuses the slot that is being freed.
  assign w_accept = i_valid && (!r_pend || i_clr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
      r_data <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= i_valid && !w_accept;
      if (w_accept) begin
        r_data <= i_data;
        r_pend <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;
  assign o_data = r_data;
  assign o_drop = r_drop;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter serialising ALU results and RF read data into an async-FIFO write port.
// Define FIFO_WR_ARB_ALU_HI_EN to send the ALU high byte; otherwise only ALU_OUT[7:0] is sent.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ALU_WIDTH  = ALU_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic [DATA_WIDTH-1:0] RD_D,
  input  logic                  RD_D_VALID,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_INC,
  output logic                  ALU_PEND,
  output logic                  RD_PEND,
  output logic                  DROP_ERR
);

`ifdef FIFO_WR_ARB_ALU_HI_EN
  localparam int ALU_SLOT_W = 2 * DATA_WIDTH;
`else
  localparam int ALU_SLOT_W = DATA_WIDTH;
  logic w_unused_alu_hi;
  assign w_unused_alu_hi = ^ALU_OUT[ALU_WIDTH-1:DATA_WIDTH];
`endif

  state_e                  r_state, w_state_nxt;
  logic                    r_ptr, w_ptr_nxt;
  logic                    w_alu_pend, w_rd_pend, w_alu_drop, w_rd_drop;
  logic                    w_alu_clr, w_rd_clr, w_wr_inc;
  logic [ALU_SLOT_W-1:0]   w_alu_data;
  logic [DATA_WIDTH-1:0]   w_rd_data, w_wr_data;

  arb_req_slot #(.W(ALU_SLOT_W)) u_alu_slot (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_valid (ALU_OUT_VALID),
    .i_data  (ALU_OUT[ALU_SLOT_W-1:0]),
    .i_clr   (w_alu_clr),
    .o_pend  (w_alu_pend),
    .o_data  (w_alu_data),
    .o_drop  (w_alu_drop)
  );

  arb_req_slot #(.W(DATA_WIDTH)) u_rd_slot (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_valid (RD_D_VALID),
    .i_data  (RD_D),
    .i_clr   (w_rd_clr),
    .o_pend  (w_rd_pend),
    .o_data  (w_rd_data),
    .o_drop  (w_rd_drop)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_wr_inc    = 1'b0;
    w_wr_data   = '0;
    w_alu_clr   = 1'b0;
    w_rd_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_alu_pend && (!w_rd_pend || !r_ptr)) w_state_nxt = SEND_ALU_LO;
        else if (w_rd_pend)                       w_state_nxt = SEND_RD;
      end
      SEND_ALU_LO: begin
        w_wr_data = w_alu_data[DATA_WIDTH-1:0];
        // Reset suppresses the strobe at once so an aborted grant writes nothing more.
        w_wr_inc  = !FIFO_FULL && !RST;
        if (w_wr_inc) begin
`ifdef FIFO_WR_ARB_ALU_HI_EN
          w_state_nxt = SEND_ALU_HI;
`else
          w_state_nxt = IDLE;
          w_alu_clr   = 1'b1;
          w_ptr_nxt   = 1'b1;
`endif
        end
      end
`ifdef FIFO_WR_ARB_ALU_HI_EN
      SEND_ALU_HI: begin
        w_wr_data = w_alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
        w_wr_inc  = !FIFO_FULL && !RST;
        if (w_wr_inc) begin
          w_state_nxt = IDLE;
          w_alu_clr   = 1'b1;
          w_ptr_nxt   = 1'b1;
        end
      end
`endif
      SEND_RD: begin
        w_wr_data = w_rd_data;
        w_wr_inc  = !FIFO_FULL && !RST;
        if (w_wr_inc) begin
          w_state_nxt = IDLE;
          w_rd_clr    = 1'b1;
          w_ptr_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign WR_DATA  = w_wr_data;
  assign WR_INC   = w_wr_inc;
  assign ALU_PEND = w_alu_pend;
  assign RD_PEND  = w_rd_pend;
  assign DROP_ERR = w_alu_drop | w_rd_drop;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb; expectations follow FIFO_WR_ARB_ALU_HI_EN
// so the same file checks either build.
module tb_fifo_wr_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  RD_D = '0;
  logic        RD_D_VALID = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic [7:0]  WR_DATA;
  logic        WR_INC, ALU_PEND, RD_PEND, DROP_ERR;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arb #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VALID (ALU_OUT_VALID),
    .RD_D          (RD_D),
    .RD_D_VALID    (RD_D_VALID),
    .FIFO_FULL     (FIFO_FULL),
    .WR_DATA       (WR_DATA),
    .WR_INC        (WR_INC),
    .ALU_PEND      (ALU_PEND),
    .RD_PEND       (RD_PEND),
    .DROP_ERR      (DROP_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, apply inputs just after the edge, let combinational outputs settle.
  task automatic next(input logic av, input logic rv, input logic full);
    @(posedge CLK);
    #1;
    ALU_OUT_VALID = av;
    RD_D_VALID    = rv;
    FIFO_FULL     = full;
    #1;
  endtask

  // Wait (bounded) for the next write strobe and check its byte and distance in cycles.
  task automatic expect_byte(input string tag, input logic [7:0] exp, input int exp_wait);
    int waited = 0;
    for (int i = 0; i < 6; i++) begin
      next(1'b0, 1'b0, 1'b0);
      waited = i + 1;
      if (WR_INC === 1'b1) break;
    end
    check({tag, "_inc"}, {31'd0, WR_INC}, 32'd1);
    check({tag, "_data"}, {24'd0, WR_DATA}, {24'd0, exp});
    check({tag, "_lat"}, waited, exp_wait);
  endtask

  task automatic idle_check(input string tag);
    next(1'b0, 1'b0, 1'b0);
    check({tag, "_idle_inc"}, {31'd0, WR_INC}, 32'd0);
    check({tag, "_idle_data"}, {24'd0, WR_DATA}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold_byte;

    // Reset state
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_inc",  {31'd0, WR_INC},   32'd0);
    check("rst_data", {24'd0, WR_DATA},  32'd0);
    check("rst_apend", {31'd0, ALU_PEND}, 32'd0);
    check("rst_rpend", {31'd0, RD_PEND},  32'd0);
    check("rst_drop", {31'd0, DROP_ERR}, 32'd0);
    RST = 1'b0;

    // Both requesters together after reset: pointer 0 grants ALU first
    ALU_OUT = 16'h1234; RD_D = 8'h3C;
    next(1'b1, 1'b1, 1'b0);
    next(1'b0, 1'b0, 1'b0);
    check("r1_apend", {31'd0, ALU_PEND}, 32'd1);
    check("r1_rpend", {31'd0, RD_PEND},  32'd1);
    check("r1_noinc", {31'd0, WR_INC},   32'd0);
    expect_byte("r1_b34", 8'h34, 1);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    expect_byte("r1_b12", 8'h12, 1);
`endif
    expect_byte("r1_b3c", 8'h3C, 2);
    idle_check("r1");
    check("r1_pend_clr", {30'd0, ALU_PEND, RD_PEND}, 32'd0);

    // Repeat from idle: pointer is back at ALU after the RD grant
    next(1'b1, 1'b1, 1'b0);
    expect_byte("r2_b34", 8'h34, 2);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    expect_byte("r2_b12", 8'h12, 1);
`endif
    expect_byte("r2_b3c", 8'h3C, 2);
    idle_check("r2");

    // Lone ALU result: first write two cycles after the pulse
    ALU_OUT = 16'hA55A;
    next(1'b1, 1'b0, 1'b0);
    expect_byte("alu_b5a", 8'h5A, 2);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    expect_byte("alu_ba5", 8'hA5, 1);
`endif
    idle_check("alu");

    // Both again: the last grant was ALU, so RD goes first
    ALU_OUT = 16'h1234; RD_D = 8'h3C;
    next(1'b1, 1'b1, 1'b0);
    expect_byte("r3_b3c", 8'h3C, 2);
    expect_byte("r3_b34", 8'h34, 2);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    expect_byte("r3_b12", 8'h12, 1);
`endif
    idle_check("r3");

    // FIFO full stalls the ALU grant on its final byte
    next(1'b1, 1'b0, 1'b0);
    next(1'b0, 1'b0, 1'b0);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    next(1'b0, 1'b0, 1'b0);
    check("full_lo_inc",  {31'd0, WR_INC},  32'd1);
    check("full_lo_data", {24'd0, WR_DATA}, 32'h34);
    hold_byte = 8'h12;
`else
    hold_byte = 8'h34;
`endif
    for (int i = 0; i < 5; i++) begin
      next(1'b0, 1'b0, 1'b1);
      check("full_hold_inc",  {31'd0, WR_INC},  32'd0);
      check("full_hold_data", {24'd0, WR_DATA}, {24'd0, hold_byte});
    end
    next(1'b0, 1'b0, 1'b0);
    check("full_rel_inc",  {31'd0, WR_INC},  32'd1);
    check("full_rel_data", {24'd0, WR_DATA}, {24'd0, hold_byte});
    idle_check("full");

    // Second RD pulse into an occupied slot while the FIFO is full
    RD_D = 8'h77;
    next(1'b0, 1'b1, 1'b1);
    next(1'b0, 1'b0, 1'b1);
    check("drop_rpend", {31'd0, RD_PEND}, 32'd1);
    next(1'b0, 1'b0, 1'b1);
    check("drop_stall_inc",  {31'd0, WR_INC},  32'd0);
    check("drop_stall_data", {24'd0, WR_DATA}, 32'h77);
    RD_D = 8'h88;
    next(1'b0, 1'b1, 1'b1);
    check("drop_pre", {31'd0, DROP_ERR}, 32'd0);
    next(1'b0, 1'b0, 1'b1);
    check("drop_pulse", {31'd0, DROP_ERR}, 32'd1);
    next(1'b0, 1'b0, 1'b1);
    check("drop_once", {31'd0, DROP_ERR}, 32'd0);
    check("drop_keep", {24'd0, WR_DATA},  32'h77);
    // Release, and pulse RD on the very cycle its byte is written: captured, no drop
    next(1'b0, 1'b1, 1'b0);
    check("drop_rel_inc",  {31'd0, WR_INC},  32'd1);
    check("drop_rel_data", {24'd0, WR_DATA}, 32'h77);
    next(1'b0, 1'b0, 1'b0);
    check("exc_nodrop", {31'd0, DROP_ERR}, 32'd0);
    check("exc_rpend",  {31'd0, RD_PEND},  32'd1);
    expect_byte("exc_b88", 8'h88, 1);
    idle_check("exc");

    // Reset in the middle of an ALU grant with RD also pending
    ALU_OUT = 16'h1234; RD_D = 8'h3C;
    next(1'b1, 1'b1, 1'b0);
    next(1'b0, 1'b0, 1'b0);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    next(1'b0, 1'b0, 1'b0);
    check("mrst_lo_data", {24'd0, WR_DATA}, 32'h34);
`endif
    next(1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check("mrst_abort_inc", {31'd0, WR_INC}, 32'd0);
    next(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    check("mrst_inc",   {31'd0, WR_INC},   32'd0);
    check("mrst_data",  {24'd0, WR_DATA},  32'd0);
    check("mrst_apend", {31'd0, ALU_PEND}, 32'd0);
    check("mrst_rpend", {31'd0, RD_PEND},  32'd0);
    for (int i = 0; i < 4; i++) begin
      next(1'b0, 1'b0, 1'b0);
      check("mrst_nowrite", {31'd0, WR_INC}, 32'd0);
    end

    // BEEF: low byte always sent, high byte only in the two-byte build
    ALU_OUT = 16'hBEEF;
    next(1'b1, 1'b0, 1'b0);
    expect_byte("beef_bef", 8'hEF, 2);
`ifdef FIFO_WR_ARB_ALU_HI_EN
    expect_byte("beef_bbe", 8'hBE, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      next(1'b0, 1'b0, 1'b0);
      check("beef_nowrite", {31'd0, WR_INC}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
